ascon_decrypt: RTL and testbench



---
 rtl/ascon_decrypt.sv | 211 +++++++++++++++++++++
 tb/tb_ascon_decrypt.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_decrypt.sv
// ascon_decrypt: ASCON-128 decryption core for whole 64-bit AD/CT blocks.
// Sequencer FSM around an iterated permutation that runs one round per clock.
// Build option: define ASCON_DEC_ROUND2_EN to unroll two rounds per clock
// (p12 in 6 cycles, p6 in 3 cycles); results are identical in both builds.
module ascon_decrypt #(
  parameter logic [63:0] IV       = 64'h80400c0600000000,
  parameter logic [63:0] PAD_WORD = 64'h8000000000000000
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic         ad_none_i,
  input  logic         ct_none_i,
  input  logic         ad_valid_i,
  output logic         ad_ready_o,
  input  logic [63:0]  ad_i,
  input  logic         ad_last_i,
  input  logic         ct_valid_i,
  output logic         ct_ready_o,
  input  logic [63:0]  ct_i,
  input  logic         ct_last_i,
  output logic         pt_valid_o,
  output logic [63:0]  pt_o,
  input  logic [127:0] tag_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         tag_ok_o
);

  // Packed state: element [0] is x0 ... element [4] is x4.
  typedef logic [4:0][63:0] state_t;

`ifdef ASCON_DEC_ROUND2_EN
  localparam logic [3:0] STEP = 4'd2;
`else
  localparam logic [3:0] STEP = 4'd1;
`endif
  // Round index held in the counter during the final cycle of a permutation.
  localparam logic [3:0] LAST_ROUND = 4'd12 - STEP;

  typedef enum logic [3:0] {
    IDLE, INIT, AD_WAIT, AD_PERM, PAD_PERM, CT_WAIT, CT_PERM, FINAL, CMP
  } fsm_t;

  fsm_t         state_reg, state_next;
  state_t       x_reg, perm_in, perm_out;
  logic [3:0]   round_reg;
  logic [63:0]  blk_reg, pt_reg;
  logic [127:0] tag_reg;
  logic         last_reg, ad_none_reg, ct_none_reg, pt_valid_reg, tag_ok_reg;
  logic         perm_first, perm_last;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // One ASCON round: constant addition, 5-bit S-box layer, linear diffusion.
  function automatic state_t ascon_round(input state_t s, input logic [3:0] r);
    state_t a, t;
    a    = s;
    a[2] = a[2] ^ {56'd0, 4'hf - r, r};
    a[0] = a[0] ^ a[4];
    a[4] = a[4] ^ a[3];
    a[2] = a[2] ^ a[1];
    t[0] = a[0] ^ (~a[1] & a[2]);
    t[1] = a[1] ^ (~a[2] & a[3]);
    t[2] = a[2] ^ (~a[3] & a[4]);
    t[3] = a[3] ^ (~a[4] & a[0]);
    t[4] = a[4] ^ (~a[0] & a[1]);
    t[1] = t[1] ^ t[0];
    t[0] = t[0] ^ t[4];
    t[3] = t[3] ^ t[2];
    t[2] = ~t[2];
    a[0] = t[0] ^ ror64(t[0], 19) ^ ror64(t[0], 28);
    a[1] = t[1] ^ ror64(t[1], 61) ^ ror64(t[1], 39);
    a[2] = t[2] ^ ror64(t[2], 1)  ^ ror64(t[2], 6);
    a[3] = t[3] ^ ror64(t[3], 10) ^ ror64(t[3], 17);
    a[4] = t[4] ^ ror64(t[4], 7)  ^ ror64(t[4], 41);
    return a;
  endfunction

  // First/last cycle of the running permutation (p12 starts at 0, p6 at 6).
  always_comb begin
    perm_first = 1'b0;
    if (state_reg == INIT || state_reg == FINAL) perm_first = (round_reg == 4'd0);
    else                                         perm_first = (round_reg == 4'd6);
    perm_last = (round_reg == LAST_ROUND);
  end

  // Permutation datapath: begin-XOR, round(s), end-XOR.
  always_comb begin
    perm_in = x_reg;
    if (perm_first) begin
      case (state_reg)
        AD_PERM:  perm_in[0] = x_reg[0] ^ blk_reg;
        PAD_PERM: perm_in[0] = x_reg[0] ^ PAD_WORD;
        CT_PERM:  perm_in[0] = blk_reg;
        FINAL: begin
          perm_in[0] = x_reg[0] ^ PAD_WORD;
          perm_in[1] = x_reg[1] ^ key_i[127:64];
          perm_in[2] = x_reg[2] ^ key_i[63:0];
        end
        default: ;
      endcase
    end
`ifdef ASCON_DEC_ROUND2_EN
    perm_out = ascon_round(ascon_round(perm_in, round_reg), round_reg + 4'd1);
`else
    perm_out = ascon_round(perm_in, round_reg);
`endif
    if (perm_last) begin
      case (state_reg)
        INIT: begin
          perm_out[3] = perm_out[3] ^ key_i[127:64];
          perm_out[4] = perm_out[4] ^ key_i[63:0] ^ {63'd0, ad_none_reg};
        end
        PAD_PERM: perm_out[4] = perm_out[4] ^ 64'd1;
        default: ;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clock_i) begin
    if (reset_i) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start_i) state_next = INIT;
      INIT:     if (perm_last) state_next = !ad_none_reg ? AD_WAIT : (ct_none_reg ? FINAL : CT_WAIT);
      AD_WAIT:  if (ad_valid_i) state_next = AD_PERM;
      AD_PERM:  if (perm_last) state_next = last_reg ? PAD_PERM : AD_WAIT;
      PAD_PERM: if (perm_last) state_next = ct_none_reg ? FINAL : CT_WAIT;
      CT_WAIT:  if (ct_valid_i) state_next = CT_PERM;
      CT_PERM:  if (perm_last) state_next = last_reg ? FINAL : CT_WAIT;
      FINAL:    if (perm_last) state_next = CMP;
      CMP:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    ad_ready_o = (state_reg == AD_WAIT);
    ct_ready_o = (state_reg == CT_WAIT);
    busy_o     = (state_reg != IDLE);
    done_o     = (state_reg == CMP);
  end

  // State words, round counter, captured blocks and result registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      x_reg        <= '0;
      round_reg    <= '0;
      blk_reg      <= '0;
      pt_reg       <= '0;
      tag_reg      <= '0;
      last_reg     <= 1'b0;
      ad_none_reg  <= 1'b0;
      ct_none_reg  <= 1'b0;
      pt_valid_reg <= 1'b0;
      tag_ok_reg   <= 1'b0;
    end else begin
      pt_valid_reg <= 1'b0;
      if (state_next == FINAL && state_reg != FINAL) tag_reg <= tag_i;
      case (state_reg)
        IDLE: if (start_i) begin
          x_reg       <= {nonce_i[63:0], nonce_i[127:64], key_i[63:0], key_i[127:64], IV};
          round_reg   <= 4'd0;
          ad_none_reg <= ad_none_i;
          ct_none_reg <= ct_none_i;
          tag_ok_reg  <= 1'b0;
        end
        AD_WAIT: if (ad_valid_i) begin
          blk_reg   <= ad_i;
          last_reg  <= ad_last_i;
          round_reg <= 4'd6;
        end
        CT_WAIT: if (ct_valid_i) begin
          blk_reg      <= ct_i;
          last_reg     <= ct_last_i;
          pt_reg       <= x_reg[0] ^ ct_i;
          pt_valid_reg <= 1'b1;
          round_reg    <= 4'd6;
        end
        INIT, AD_PERM, PAD_PERM, CT_PERM, FINAL: begin
          x_reg <= perm_out;
          if (perm_last) begin
            round_reg <= (state_next == PAD_PERM) ? 4'd6 : 4'd0;
            if (state_reg == FINAL)
              tag_ok_reg <= (({perm_out[3], perm_out[4]} ^ key_i) == tag_reg);
          end else begin
            round_reg <= round_reg + STEP;
          end
        end
        default: ;
      endcase
    end
  end

  assign pt_o       = pt_reg;
  assign pt_valid_o = pt_valid_reg;
  assign tag_ok_o   = tag_ok_reg;

endmodule

// File: tb/tb_ascon_decrypt.sv
// tb_ascon_decrypt: directed + randomized checks of ascon_decrypt against an
// ASCON-128 encryption model built from the S-box table and rotation amounts.
module tb_ascon_decrypt;
  logic         clk = 1'b0;
  logic         reset_i, start_i, ad_none_i, ct_none_i;
  logic [127:0] key_i, nonce_i, tag_i;
  logic         ad_valid_i, ad_ready_o, ad_last_i;
  logic [63:0]  ad_i;
  logic         ct_valid_i, ct_ready_o, ct_last_i;
  logic [63:0]  ct_i;
  logic         pt_valid_o, busy_o, done_o, tag_ok_o;
  logic [63:0]  pt_o;

  always #5 clk = ~clk;

  ascon_decrypt dut (
    .clock_i(clk), .reset_i(reset_i), .start_i(start_i), .key_i(key_i),
    .nonce_i(nonce_i), .ad_none_i(ad_none_i), .ct_none_i(ct_none_i),
    .ad_valid_i(ad_valid_i), .ad_ready_o(ad_ready_o), .ad_i(ad_i), .ad_last_i(ad_last_i),
    .ct_valid_i(ct_valid_i), .ct_ready_o(ct_ready_o), .ct_i(ct_i), .ct_last_i(ct_last_i),
    .pt_valid_o(pt_valid_o), .pt_o(pt_o), .tag_i(tag_i), .busy_o(busy_o),
    .done_o(done_o), .tag_ok_o(tag_ok_o)
  );

`ifdef ASCON_DEC_ROUND2_EN
  localparam int LAT = 14;
`else
  localparam int LAT = 26;
`endif
  localparam logic [63:0]  IV_W  = 64'h80400c0600000000;
  localparam logic [63:0]  PAD_W = 64'h8000000000000000;
  localparam logic [127:0] KAT_K = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KAT_T = 128'hE355159F292911F794CB1432A0103A8A;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  int checks = 0;
  int passes = 0;

  logic [63:0]  ms [5];
  logic [63:0]  mt [5];
  logic [63:0]  m_ad [$];
  logic [63:0]  m_pt [$];
  logic [63:0]  m_ct [$];
  logic [127:0] m_tag;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Last nr rounds of the ASCON permutation applied to ms, column-wise S-box.
  task automatic model_perm(input int nr);
    for (int i = 12 - nr; i < 12; i++) begin
      ms[2] = ms[2] ^ 64'(((15 - i) << 4) | i);
      for (int b = 0; b < 64; b++) begin
        logic [4:0] col;
        logic [4:0] o;
        col = {ms[0][b], ms[1][b], ms[2][b], ms[3][b], ms[4][b]};
        o = SBOX[col];
        mt[0][b] = o[4]; mt[1][b] = o[3]; mt[2][b] = o[2]; mt[3][b] = o[1]; mt[4][b] = o[0];
      end
      ms[0] = mt[0] ^ rotr(mt[0], 19) ^ rotr(mt[0], 28);
      ms[1] = mt[1] ^ rotr(mt[1], 61) ^ rotr(mt[1], 39);
      ms[2] = mt[2] ^ rotr(mt[2], 1)  ^ rotr(mt[2], 6);
      ms[3] = mt[3] ^ rotr(mt[3], 10) ^ rotr(mt[3], 17);
      ms[4] = mt[4] ^ rotr(mt[4], 7)  ^ rotr(mt[4], 41);
    end
  endtask

  // Random AD/PT of the given block counts, encrypted into m_ct / m_tag.
  task automatic make_msg(input int na, input int nc, input logic [127:0] k, input logic [127:0] n);
    m_ad.delete(); m_pt.delete(); m_ct.delete();
    for (int i = 0; i < na; i++) m_ad.push_back({$urandom, $urandom});
    for (int i = 0; i < nc; i++) m_pt.push_back({$urandom, $urandom});
    ms[0] = IV_W; ms[1] = k[127:64]; ms[2] = k[63:0]; ms[3] = n[127:64]; ms[4] = n[63:0];
    model_perm(12);
    ms[3] ^= k[127:64]; ms[4] ^= k[63:0];
    if (na > 0) begin
      foreach (m_ad[i]) begin ms[0] ^= m_ad[i]; model_perm(6); end
      ms[0] ^= PAD_W; model_perm(6);
    end
    ms[4] ^= 64'd1;
    foreach (m_pt[i]) begin ms[0] ^= m_pt[i]; m_ct.push_back(ms[0]); model_perm(6); end
    ms[0] ^= PAD_W; ms[1] ^= k[127:64]; ms[2] ^= k[63:0];
    model_perm(12);
    m_tag = {ms[3], ms[4]} ^ k;
  endtask

  // Runs one message through the DUT using m_ad / m_ct, checking pt and result.
  task automatic run_msg(input string name, input logic [127:0] k, input logic [127:0] n,
                         input int n_ad, input int n_ct, input logic [127:0] tag_in,
                         input logic exp_ok, input bit hold_ct, input bit poke);
    int cyc, ad_idx, ct_idx, pt_idx, done_cyc;
    bit done_seen, ad_x, ct_x;
    @(negedge clk);
    start_i = 1'b1; key_i = k; nonce_i = n; tag_i = tag_in;
    ad_none_i = (n_ad == 0); ct_none_i = (n_ct == 0);
    ad_valid_i = 1'b0; ct_valid_i = hold_ct;
    @(posedge clk);
    cyc = 2; ad_idx = 0; ct_idx = 0; pt_idx = 0; done_seen = 0; done_cyc = 0;
    while (!done_seen && cyc < 400) begin
      @(negedge clk);
      start_i = poke && (cyc == 4 || cyc == 9);
      nonce_i = {$urandom, $urandom, $urandom, $urandom};
      ad_none_i = 1'($urandom); ct_none_i = 1'($urandom);
      if (pt_valid_o) begin
        if (pt_idx < n_ct) check({name, "_pt"}, {64'd0, pt_o}, {64'd0, m_pt[pt_idx]});
        else check({name, "_pt_extra"}, 128'(pt_idx + 1), 128'(n_ct));
        pt_idx++;
      end
      if (done_o) begin
        done_seen = 1; done_cyc = cyc;
        check({name, "_tag_ok"}, {127'd0, tag_ok_o}, {127'd0, exp_ok});
      end else begin
        check({name, "_busy"}, {127'd0, busy_o}, 128'd1);
      end
      if (ad_idx < n_ad) check({name, "_ct_ready_early"}, {127'd0, ct_ready_o}, 128'd0);
      if (ad_ready_o) check({name, "_ad_ready_extra"}, 128'(ad_idx < n_ad), 128'd1);
      ad_valid_i = (ad_idx < n_ad) && ($urandom_range(0, 3) != 0);
      ad_i = (ad_idx < n_ad) ? m_ad[ad_idx] : {$urandom, $urandom};
      ad_last_i = ad_valid_i ? (ad_idx == n_ad - 1) : 1'($urandom);
      ct_valid_i = hold_ct || ((ct_idx < n_ct) && ($urandom_range(0, 3) != 0));
      ct_i = (ct_idx < n_ct) ? m_ct[ct_idx] : {$urandom, $urandom};
      ct_last_i = (ct_idx < n_ct) ? (ct_idx == n_ct - 1) : 1'($urandom);
      ad_x = ad_valid_i && ad_ready_o;
      ct_x = ct_valid_i && ct_ready_o;
      if (ct_x && ct_idx >= n_ct) check({name, "_ct_xfer_extra"}, 128'(ct_idx + 1), 128'(n_ct));
      @(posedge clk);
      if (ad_x) ad_idx++;
      if (ct_x) ct_idx++;
      cyc++;
    end
    start_i = 1'b0; ad_valid_i = 1'b0; ct_valid_i = 1'b0;
    check({name, "_done_seen"}, {127'd0, done_seen}, 128'd1);
    check({name, "_ad_count"}, 128'(ad_idx), 128'(n_ad));
    check({name, "_pt_count"}, 128'(pt_idx), 128'(n_ct));
    if (n_ad == 0 && n_ct == 0) check({name, "_latency"}, 128'(done_cyc), 128'(LAT));
    @(negedge clk);
    check({name, "_done_pulse"}, {127'd0, done_o}, 128'd0);
    check({name, "_idle"}, {127'd0, busy_o}, 128'd0);
    check({name, "_tag_ok_hold"}, {127'd0, tag_ok_o}, {127'd0, exp_ok});
    $display("msg %s: ad=%0d ct=%0d done_cyc=%0d tag_ok=%0b pt_pulses=%0d",
             name, n_ad, n_ct, done_cyc, tag_ok_o, pt_idx);
  endtask

  initial begin
    logic [127:0] k, n;
    bit seen;
    reset_i = 1'b1; start_i = 1'b0; key_i = '0; nonce_i = '0; tag_i = '0;
    ad_none_i = 1'b0; ct_none_i = 1'b0; ad_valid_i = 1'b0; ad_i = '0; ad_last_i = 1'b0;
    ct_valid_i = 1'b0; ct_i = '0; ct_last_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {120'd0, busy_o, done_o, pt_valid_o, tag_ok_o, ad_ready_o, ct_ready_o, 2'b00}, 128'd0);
    check("rst_pt", {64'd0, pt_o}, 128'd0);
    reset_i = 1'b0;

    // Empty-message known answer, then the same with a corrupted tag bit.
    run_msg("kat", KAT_K, KAT_K, 0, 0, KAT_T, 1'b1, 1'b0, 1'b0);
    run_msg("kat_bad", KAT_K, KAT_K, 0, 0, KAT_T ^ 128'd1, 1'b0, 1'b0, 1'b0);

    // 2 AD + 3 CT blocks, ct_valid held high throughout, start poked while busy.
    k = {$urandom, $urandom, $urandom, $urandom};
    n = {$urandom, $urandom, $urandom, $urandom};
    make_msg(2, 3, k, n);
    run_msg("ad2_ct3", k, n, 2, 3, m_tag, 1'b1, 1'b1, 1'b1);

    // Random block counts, alternating ct_valid holding, one bad tag.
    for (int t = 0; t < 6; t++) begin
      int na, nc;
      na = $urandom_range(0, 3); nc = $urandom_range(0, 3);
      k = {$urandom, $urandom, $urandom, $urandom};
      n = {$urandom, $urandom, $urandom, $urandom};
      make_msg(na, nc, k, n);
      run_msg($sformatf("rnd%0d", t), k, n, na, nc, (t == 3) ? (m_tag ^ (128'd1 << 77)) : m_tag,
              (t == 3) ? 1'b0 : 1'b1, t[0], t == 4);
    end

    // Reset during CT_PERM aborts the message silently.
    k = {$urandom, $urandom, $urandom, $urandom};
    n = {$urandom, $urandom, $urandom, $urandom};
    make_msg(0, 2, k, n);
    @(negedge clk);
    start_i = 1'b1; key_i = k; nonce_i = n; ad_none_i = 1'b1; ct_none_i = 1'b0; tag_i = m_tag;
    @(negedge clk);
    start_i = 1'b0; ct_valid_i = 1'b1; ct_i = m_ct[0]; ct_last_i = 1'b0;
    for (int i = 0; i < 40 && !ct_ready_o; i++) @(negedge clk);
    check("abort_ct_ready", {127'd0, ct_ready_o}, 128'd1);
    @(negedge clk);
    ct_valid_i = 1'b0;
    check("abort_pt_valid", {127'd0, pt_valid_o}, 128'd1);
    check("abort_pt", {64'd0, pt_o}, {64'd0, m_pt[0]});
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check("abort_outputs", {120'd0, busy_o, done_o, pt_valid_o, tag_ok_o, ad_ready_o, ct_ready_o, 2'b00}, 128'd0);
    check("abort_pt_cleared", {64'd0, pt_o}, 128'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o || pt_valid_o || busy_o) seen = 1;
    end
    check("abort_silent", {127'd0, seen}, 128'd0);
    $display("msg abort: reset in CT_PERM, outputs cleared");

    run_msg("kat_after_abort", KAT_K, KAT_K, 0, 0, KAT_T, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
